// File: rtl/elevator_state_ctrl_n.sv
// Elevator state controller for FLOORS floors with sweep (SCAN) direction
// scheduling, internal run/door timing, door hold/close/overload handling
// and per-floor service pulses that clear the upstream request register.
module elevator_state_ctrl_n #(
  parameter int FLOORS     = 4,
  parameter int RUN_TICKS  = 64,
  parameter int DOOR_TICKS = 96,
  parameter int CW         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              switch,
  input  logic [FLOORS-1:0] allReq_reg,
  input  logic              door_hold,
  input  logic              door_close,
  input  logic              overload,
  output logic              opendoor,
  output logic              mv2nxt,
  output logic [1:0]        ud_mode,
  output logic [2:0]        state,
  output logic [FLOORS-1:0] position,
  output logic [FLOORS-1:0] served
);

  typedef enum logic [2:0] {
    S_OFF   = 3'b000,
    S_PAUSE = 3'b001,
    S_MOVE  = 3'b010,
    S_OPEN  = 3'b011
  } state_t;

  localparam logic [1:0]        UD_IDLE   = 2'b00;
  localparam logic [1:0]        UD_UP     = 2'b01;
  localparam logic [1:0]        UD_DN     = 2'b10;
  localparam logic [FLOORS-1:0] POS_ONE   = {{(FLOORS-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     RUN_LAST  = CW'(RUN_TICKS - 1);
  localparam logic [CW-1:0]     DOOR_LAST = CW'(DOOR_TICKS - 1);

  state_t            state_q, state_d;
  logic [FLOORS-1:0] pos_q, pos_d;
  logic [FLOORS-1:0] served_q, served_d;
  logic [1:0]        ud_q, ud_d, ud_next;
  logic [1:0]        hop_q, hop_d;
  logic              open_q, open_d;
  logic              mv_q, mv_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [FLOORS-1:0] pos_shl, above_mask, below_mask;
  logic              up_need, down_need, here_req;

  // Floors strictly above / below the car, derived from the one-hot position.
  assign pos_shl    = pos_q << 1;
  assign above_mask = ~(pos_shl - POS_ONE);
  assign below_mask = pos_q - POS_ONE;
  assign up_need    = |(allReq_reg & above_mask);
  assign down_need  = |(allReq_reg & below_mask);
  assign here_req   = |(allReq_reg & pos_q);

  // SCAN direction: keep sweeping while work remains ahead, else turn (up wins ties).
  always_comb begin
    ud_next = UD_IDLE;
    if (allReq_reg == '0)
      ud_next = UD_IDLE;
    else if (ud_q == UD_UP && up_need)
      ud_next = UD_UP;
    else if (ud_q == UD_DN && down_need)
      ud_next = UD_DN;
    else if (up_need)
      ud_next = UD_UP;
    else if (down_need)
      ud_next = UD_DN;
  end

  // Next-state and registered-output logic; hop_q pins the direction of the
  // hop in progress so request changes mid-move cannot redirect it.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    ud_d     = ud_q;
    hop_d    = hop_q;
    open_d   = open_q;
    mv_d     = mv_q;
    served_d = '0;
    cnt_d    = cnt_q;
    if (state_q != S_OFF)
      ud_d = ud_next;
    case (state_q)
      S_OFF: state_d = S_PAUSE;
      S_PAUSE: begin
        if (here_req) begin
          state_d  = S_OPEN;
          open_d   = 1'b1;
          served_d = pos_q;
          cnt_d    = '0;
        end else if (ud_next != UD_IDLE && !overload) begin
          state_d = S_MOVE;
          mv_d    = 1'b1;
          hop_d   = ud_next;
          cnt_d   = '0;
        end
      end
      S_MOVE: begin
        if (cnt_q == RUN_LAST) begin
          state_d = S_PAUSE;
          mv_d    = 1'b0;
          cnt_d   = '0;
          if (hop_q == UD_UP && !pos_q[FLOORS-1])
            pos_d = pos_q << 1;
          else if (hop_q == UD_DN && !pos_q[0])
            pos_d = pos_q >> 1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_OPEN: begin
        // A fresh call at this floor re-announces service; served_q gates it so
        // the still-set request bit during the pulse does not retrigger.
        if (door_hold || overload || (here_req && served_q == '0)) begin
          cnt_d = '0;
          if (here_req && served_q == '0)
            served_d = pos_q;
        end else if (door_close || cnt_q == DOOR_LAST) begin
          state_d = S_PAUSE;
          open_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // State register; reset or master switch off parks the car at ground.
  always_ff @(posedge clk) begin
    if (rst || !switch) begin
      state_q  <= S_OFF;
      pos_q    <= POS_ONE;
      ud_q     <= UD_IDLE;
      hop_q    <= UD_IDLE;
      open_q   <= 1'b0;
      mv_q     <= 1'b0;
      served_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      ud_q     <= ud_d;
      hop_q    <= hop_d;
      open_q   <= open_d;
      mv_q     <= mv_d;
      served_q <= served_d;
      cnt_q    <= cnt_d;
    end
  end

  assign state    = state_q;
  assign position = pos_q;
  assign ud_mode  = ud_q;
  assign opendoor = open_q;
  assign mv2nxt   = mv_q;
  assign served   = served_q;

endmodule

// File: tb/tb_elevator_state_ctrl_n.sv
// Bench for elevator_state_ctrl_n: a 4-floor instance checked cycle by cycle
// against a floor-index reference model, plus an 8-floor instance for a
// long sweep to the top floor.
module tb_elevator_state_ctrl_n;
  localparam int F = 4, RT = 4, DT = 6;
  localparam int M_OFF = 0, M_PAUSE = 1, M_MOVE = 2, M_OPEN = 3;

  logic clk = 1'b0;
  logic rst, sw, hold, close, ovl;
  logic [3:0] req;
  logic opendoor, mv2nxt;
  logic [1:0] ud_mode;
  logic [2:0] state;
  logic [3:0] position, served;

  logic [7:0] req8;
  logic opendoor8, mv2nxt8;
  logic [1:0] ud_mode8;
  logic [2:0] state8;
  logic [7:0] position8, served8;

  int n_cmp = 0, n_bad = 0;
  int m_mode, m_floor, m_dir, m_hop, m_tmove, m_tdoor, m_srv;
  logic [14:0] dut_vec;

  elevator_state_ctrl_n #(.FLOORS(F), .RUN_TICKS(RT), .DOOR_TICKS(DT), .CW(4)) dut (
    .clk(clk), .rst(rst), .switch(sw), .allReq_reg(req), .door_hold(hold),
    .door_close(close), .overload(ovl), .opendoor(opendoor), .mv2nxt(mv2nxt),
    .ud_mode(ud_mode), .state(state), .position(position), .served(served));

  elevator_state_ctrl_n #(.FLOORS(8), .RUN_TICKS(3), .DOOR_TICKS(3), .CW(4)) dut8 (
    .clk(clk), .rst(rst), .switch(sw), .allReq_reg(req8), .door_hold(1'b0),
    .door_close(1'b0), .overload(1'b0), .opendoor(opendoor8), .mv2nxt(mv2nxt8),
    .ud_mode(ud_mode8), .state(state8), .position(position8), .served(served8));

  always #5 clk = ~clk;

  assign dut_vec = {state, position, ud_mode, opendoor, mv2nxt, served};

  function automatic logic [3:0] model_served();
    return (m_srv >= 0) ? (4'b0001 << m_srv) : 4'b0000;
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [3:0] p;
    logic [1:0] u;
    p = 4'b0001 << m_floor;
    u = (m_dir > 0) ? 2'b01 : (m_dir < 0) ? 2'b10 : 2'b00;
    return {3'(m_mode), p, u, (m_mode == M_OPEN), (m_mode == M_MOVE), model_served()};
  endfunction

  // Reference behaviour by floor number, direction sign and elapsed-cycle timers.
  task automatic model_step();
    bit ab, be, here;
    int nd, prev_srv;
    ab = 0; be = 0;
    for (int f = 0; f < F; f++) begin
      if (req[f] && f > m_floor) ab = 1;
      if (req[f] && f < m_floor) be = 1;
    end
    here = req[m_floor];
    prev_srv = m_srv;
    m_srv = -1;
    if (rst || !sw) begin
      m_mode = M_OFF; m_floor = 0; m_dir = 0; m_hop = 0; m_tmove = 0; m_tdoor = 0;
    end else begin
      nd = 0;
      if (m_mode != M_OFF && req != 4'b0000) begin
        if (m_dir > 0 && ab) nd = 1;
        else if (m_dir < 0 && be) nd = -1;
        else if (ab) nd = 1;
        else if (be) nd = -1;
      end
      case (m_mode)
        M_OFF: m_mode = M_PAUSE;
        M_PAUSE: begin
          if (here) begin m_mode = M_OPEN; m_srv = m_floor; m_tdoor = 0; end
          else if (nd != 0 && !ovl) begin m_mode = M_MOVE; m_hop = nd; m_tmove = 0; end
        end
        M_MOVE: begin
          m_tmove++;
          if (m_tmove == RT) begin
            m_tmove = 0;
            m_mode = M_PAUSE;
            if (m_floor + m_hop >= 0 && m_floor + m_hop < F) m_floor += m_hop;
          end
        end
        default: begin
          if (here && prev_srv < 0) begin m_srv = m_floor; m_tdoor = 0; end
          else if (hold || ovl) m_tdoor = 0;
          else begin
            m_tdoor++;
            if (close || m_tdoor == DT) begin m_mode = M_PAUSE; m_tdoor = 0; end
          end
        end
      endcase
      m_dir = nd;
    end
  endtask

  // Upstream register: clears served floors, ORs in new calls; then one clock.
  task automatic step(input logic [3:0] nr);
    @(negedge clk);
    req = (req & ~model_served()) | nr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; sw = 0;
    step(4'b0000);
    step(4'b0000);
    n_cmp++;
    if (state !== 3'b000 || position !== 4'b0001 || ud_mode !== 2'b00 ||
        opendoor !== 1'b0 || mv2nxt !== 1'b0 || served !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got st=%b pos=%b ud=%b od=%b mv=%b srv=%b, expected 000 0001 00 0 0 0000",
               state, position, ud_mode, opendoor, mv2nxt, served);
    end
    sw = 1;
    step(4'b0000);
    n_cmp++;
    if (state !== 3'b000) begin
      n_bad++; $display("FAIL reset_priority: got state %b, expected 000", state);
    end
    rst = 0;
    step(4'b0000);
    n_cmp++;
    if (state !== 3'b001) begin
      n_bad++; $display("FAIL reset_to_pause: got state %b, expected 001", state);
    end
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL reset_model: got %b, expected %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_single_hop();
    int n_mv, n_open, n_srv, mv_at_f1;
    bit done, saw_up;
    logic [3:0] srv_seen;
    n_mv = 0; n_open = 0; n_srv = 0; mv_at_f1 = -1; done = 0; saw_up = 0; srv_seen = 0;
    step(4'b0100);
    for (int k = 0; k < 60; k++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL hop_model @%0t: got %b, expected %b", $time, dut_vec, exp_vec());
      end
      if (mv2nxt) n_mv++;
      if (opendoor) n_open++;
      if (served != 4'b0000) begin n_srv++; srv_seen = served; end
      if (position == 4'b0010 && mv_at_f1 < 0) mv_at_f1 = n_mv;
      if (ud_mode == 2'b01) saw_up = 1;
      if (n_open > 0 && !opendoor) begin done = 1; break; end
      step(4'b0000);
    end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL hop_timeout: door never closed within 60 cycles"); end
    n_cmp++;
    if (mv_at_f1 != RT) begin n_bad++; $display("FAIL hop_first_floor: got %0d move cycles, expected %0d", mv_at_f1, RT); end
    n_cmp++;
    if (n_mv != 2 * RT) begin n_bad++; $display("FAIL hop_move_cycles: got %0d, expected %0d", n_mv, 2 * RT); end
    n_cmp++;
    if (n_open != DT) begin n_bad++; $display("FAIL hop_open_cycles: got %0d, expected %0d", n_open, DT); end
    n_cmp++;
    if (n_srv != 1 || srv_seen !== 4'b0100) begin
      n_bad++; $display("FAIL hop_served: got %0d pulses last %b, expected 1 pulse 0100", n_srv, srv_seen);
    end
    n_cmp++;
    if (position !== 4'b0100 || !saw_up) begin
      n_bad++; $display("FAIL hop_final: got pos %b up_seen %0d, expected 0100 1", position, saw_up);
    end
  endtask

  task automatic test_scan();
    logic [1:0] prev_ud;
    logic [1:0] ud_log[$];
    logic [3:0] srv_log[$];
    bit added, seen_open;
    seen_open = 0;
    step(4'b0010);
    for (int k = 0; k < 60; k++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL scan_setup_model @%0t: got %b, expected %b", $time, dut_vec, exp_vec());
      end
      if (opendoor) seen_open = 1;
      else if (seen_open) break;
      step(4'b0000);
    end
    n_cmp++;
    if (position !== 4'b0010 || opendoor !== 1'b0) begin
      n_bad++; $display("FAIL scan_setup: got pos %b od %b, expected 0010 0", position, opendoor);
    end
    prev_ud = ud_mode; added = 0;
    step(4'b1000);
    for (int k = 0; k < 200; k++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL scan_model @%0t: got %b, expected %b", $time, dut_vec, exp_vec());
      end
      if (ud_mode != prev_ud && ud_mode != 2'b00) ud_log.push_back(ud_mode);
      prev_ud = ud_mode;
      if (served != 4'b0000) srv_log.push_back(served);
      if (srv_log.size() == 2 && !opendoor) break;
      if (mv2nxt && !added) begin added = 1; step(4'b0001); end
      else step(4'b0000);
    end
    n_cmp++;
    if (srv_log.size() != 2 || srv_log[0] !== 4'b1000 || srv_log[1] !== 4'b0001) begin
      n_bad++; $display("FAIL scan_order: got %0d services first %b, expected 1000 then 0001",
                        srv_log.size(), (srv_log.size() > 0) ? srv_log[0] : 4'b0000);
    end
    n_cmp++;
    if (ud_log.size() != 2 || ud_log[0] !== 2'b01 || ud_log[1] !== 2'b10) begin
      n_bad++; $display("FAIL scan_ud_sequence: got %0d changes, expected 01 then 10", ud_log.size());
    end
  endtask

  task automatic test_door();
    int n_open;
    n_open = 0;
    step(4'b0001);
    if (opendoor) n_open++;
    hold = 1;
    for (int k = 0; k < 10; k++) begin
      step(4'b0000);
      if (opendoor) n_open++;
    end
    hold = 0;
    for (int k = 0; k < 40; k++) begin
      step(4'b0000);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL door_hold_model @%0t: got %b, expected %b", $time, dut_vec, exp_vec());
      end
      if (opendoor) n_open++;
      else break;
    end
    n_cmp++;
    if (n_open != DT + 10) begin n_bad++; $display("FAIL door_hold_time: got %0d open cycles, expected %0d", n_open, DT + 10); end
    step(4'b0001);
    step(4'b0000);
    n_cmp++;
    if (opendoor !== 1'b1) begin n_bad++; $display("FAIL door_before_close: got od %b, expected 1", opendoor); end
    close = 1;
    step(4'b0000);
    close = 0;
    n_cmp++;
    if (opendoor !== 1'b0 || state !== 3'b001) begin
      n_bad++; $display("FAIL door_close_pulse: got od %b st %b, expected 0 001", opendoor, state);
    end
    step(4'b0001);
    hold = 1; close = 1;
    step(4'b0000);
    hold = 0; close = 0;
    n_cmp++;
    if (opendoor !== 1'b1 || state !== 3'b011) begin
      n_bad++; $display("FAIL door_hold_beats_close: got od %b st %b, expected 1 011", opendoor, state);
    end
    for (int k = 0; k < 20 && opendoor; k++) step(4'b0000);
    n_cmp++;
    if (dut_vec !== exp_vec() || opendoor !== 1'b0) begin
      n_bad++; $display("FAIL door_settle: got %b, expected %b with door shut", dut_vec, exp_vec());
    end
  endtask

  task automatic test_overload();
    int n_shut, n_mv;
    n_shut = 0; n_mv = 0;
    step(4'b0001);
    ovl = 1;
    for (int k = 0; k < 3 * DT; k++) begin
      close = (k == 5);
      step(4'b0000);
      if (!opendoor) n_shut++;
    end
    close = 0;
    n_cmp++;
    if (n_shut != 0) begin n_bad++; $display("FAIL ovl_door_open: got %0d closed cycles, expected 0", n_shut); end
    ovl = 0;
    for (int k = 0; k < 20 && opendoor; k++) step(4'b0000);
    ovl = 1;
    step(4'b1000);
    for (int k = 0; k < 20; k++) begin
      step(4'b0000);
      if (mv2nxt || state !== 3'b001) n_mv++;
    end
    n_cmp++;
    if (n_mv != 0) begin n_bad++; $display("FAIL ovl_blocks_move: got %0d moving cycles, expected 0", n_mv); end
    ovl = 0;
    step(4'b0000);
    n_cmp++;
    if (mv2nxt !== 1'b1 || ud_mode !== 2'b01) begin
      n_bad++; $display("FAIL ovl_release: got mv %b ud %b, expected 1 01", mv2nxt, ud_mode);
    end
  endtask

  task automatic test_abort();
    bit found;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (position == 4'b0010 && mv2nxt) begin found = 1; break; end
      step(4'b0000);
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL abort_setup: got pos %b mv %b, expected 0010 1", position, mv2nxt); end
    step(4'b0000);
    step(4'b0000);
    sw = 0;
    step(4'b0000);
    n_cmp++;
    if (state !== 3'b000 || position !== 4'b0001 || mv2nxt !== 1'b0 || ud_mode !== 2'b00) begin
      n_bad++; $display("FAIL abort_off: got st %b pos %b mv %b ud %b, expected 000 0001 0 00",
                        state, position, mv2nxt, ud_mode);
    end
    req = 4'b0000;
    sw = 1;
    step(4'b0000);
    n_cmp++;
    if (dut_vec !== exp_vec() || state !== 3'b001) begin
      n_bad++; $display("FAIL abort_resume: got %b, expected %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_generic();
    logic [7:0] prev, srv8;
    int hops;
    hops = 0; srv8 = 0;
    rst = 1;
    step(4'b0000);
    rst = 0;
    step(4'b0000);
    req8 = 8'h80;
    prev = position8;
    for (int k = 0; k < 200; k++) begin
      step(4'b0000);
      n_cmp++;
      if (!$onehot(position8)) begin n_bad++; $display("FAIL gen_onehot: got %b, expected one bit set", position8); end
      if (position8 !== prev) begin
        n_cmp++;
        if (position8 !== (prev << 1)) begin
          n_bad++; $display("FAIL gen_hop: got %b, expected %b", position8, prev << 1);
        end
        hops++;
        prev = position8;
      end
      if (served8 != 8'h00) begin srv8 = served8; req8 = req8 & ~served8; break; end
    end
    n_cmp++;
    if (hops != 7 || position8 !== 8'h80 || srv8 !== 8'h80) begin
      n_bad++; $display("FAIL gen_top_floor: got %0d hops pos %b srv %b, expected 7 10000000 10000000",
                        hops, position8, srv8);
    end
  endtask

  task automatic test_random();
    logic [3:0] nr;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 39) == 0) hold = ~hold;
      if ($urandom_range(0, 59) == 0) ovl = ~ovl;
      close = ($urandom_range(0, 19) == 0);
      sw    = ($urandom_range(0, 399) != 0);
      rst   = ($urandom_range(0, 599) == 0);
      nr    = ($urandom_range(0, 9) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      step(nr);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random_model @%0t: got %b, expected %b", $time, dut_vec, exp_vec());
      end
    end
    hold = 0; ovl = 0; close = 0; sw = 1; rst = 0;
  endtask

  initial begin
    rst = 1; sw = 0; req = 4'b0000; hold = 0; close = 0; ovl = 0; req8 = 8'h00;
    m_mode = M_OFF; m_floor = 0; m_dir = 0; m_hop = 0; m_tmove = 0; m_tdoor = 0; m_srv = -1;
    test_reset();
    test_single_hop();
    test_scan();
    test_door();
    test_overload();
    test_abort();
    test_generic();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/elevator_state_ctrl_n.md
Name: elevator_state_ctrl_n

Overview:
Parametrised successor to the 4-floor elevator state controller. It is generalised to FLOORS floors. Run and door timing are counted internally instead of arriving as external endRun/endOpen strobes. Direction uses sweep (SCAN) scheduling rather than fixed up-priority, and the block adds door-hold, door-close and overload inputs plus per-floor service pulses that clear the request register upstream.

Parameters:
FLOORS, 4, number of floors (>=2); position is FLOORS-bit one-hot, bit0 = ground floor.
RUN_TICKS, 64, clk cycles to travel one floor (>=2).
DOOR_TICKS, 96, clk cycles the door stays open (>=2).
CW, 8, counter width; must satisfy 2^CW > max(RUN_TICKS, DOOR_TICKS).

Ports:
clk  in  1  system clock (32 Hz in the elevator top level).
rst  in  1  synchronous, active-high reset.
switch  in  1  elevator master switch; 0 forces the OFF state.
allReq_reg  in  FLOORS  registered pending requests, one bit per floor.
door_hold  in  1  open-door button; level-sensitive.
door_close  in  1  close-door button; single-cycle pulse.
overload  in  1  car overweight; level-sensitive.
opendoor  out  1  door open command.
mv2nxt  out  1  motor run command.
ud_mode  out  2  00 idle, 01 up, 10 down.
state  out  3  000 OFF, 001 PAUSE, 010 MOVE, 011 OPEN.
position  out  FLOORS  one-hot current floor.
served  out  FLOORS  one-cycle pulse clearing the request of the floor being served.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset and switch: rst=1, or switch=0, on any edge gives state=OFF, position=1 (ground), opendoor=0, mv2nxt=0, ud_mode=00, served=0, counters=0. rst has priority over switch. Either one aborts MOVE or OPEN immediately, with no position update.
- Need signals (combinational, from the current position):
  - up_need = |(allReq_reg & ~((position<<1)-1)) excluding the current floor.
  - down_need = |(allReq_reg & (position-1)).
- Direction is registered each cycle outside OFF (SCAN):
  - allReq_reg==0 gives ud_mode=00.
  - ud_mode=01 with up_need: hold 01.
  - ud_mode=10 with down_need: hold 10.
  - Otherwise up_need gives 01, else down_need gives 10, else 00.
  - Ties from idle go up.
- OFF to PAUSE on the first cycle with switch=1 and rst=0.
- PAUSE:
  - Request at the current floor (allReq_reg & position nonzero): go to OPEN next cycle, opendoor=1, served=position for exactly 1 cycle, door counter=0.
  - Else, if the direction being entered has need and overload=0: go to MOVE, mv2nxt=1, run counter=0.
  - Else stay in PAUSE.
- MOVE:
  - The run counter increments every cycle.
  - At count RUN_TICKS-1: position shifts left (ud_mode 01) or right (10), mv2nxt=0, state goes to PAUSE, counter clears.
  - Total MOVE duration is exactly RUN_TICKS cycles.
  - position never shifts past bit FLOORS-1 or bit0. If a shift would leave the range, the block holds position and goes to PAUSE (defensive; unreachable under SCAN).
  - Requests changing mid-move do not alter the current floor hop.
- OPEN:
  - The door counter increments each cycle.
  - door_hold=1 or overload=1 reloads the counter to 0 (door stays open).
  - door_close pulse with overload=0 forces immediate close.
  - At count DOOR_TICKS-1, or on close: opendoor=0, state goes to PAUSE.
  - A request arriving for the current floor while in OPEN re-pulses served and reloads the counter.
- Simultaneous events:
  - door_close together with door_hold: hold wins.
  - overload blocks MOVE entry and door close.
- Outputs are all registered; no combinational path from inputs to outputs.
- position always has exactly one bit set.

Test Plan:
- Reset/switch, FLOORS=4: rst=1 for 2 cycles, then switch=1 → state 000 then 001; position=0001; all other outputs 0.
- Single hop, RUN_TICKS=4, allReq_reg=0100 from floor 0:
  - ud_mode=01 and mv2nxt=1.
  - position becomes 0010 after 4 MOVE cycles, then 0100 after 4 more.
  - Then OPEN with served=0100 for 1 cycle.
  - opendoor is high for DOOR_TICKS cycles.
- SCAN: at floor 1 moving up with requests 1000 and 0001 → serves floor 3 before reversing; ud_mode sequence 01 then 10.
- Door control:
  - door_hold high 10 cycles during OPEN extends open time by 10.
  - door_close pulse closes next cycle.
  - overload=1 keeps the door open and blocks MOVE indefinitely.
- Abort: switch=0 mid-MOVE at count 2 → next cycle OFF, position=0001, mv2nxt=0.
- Generic: FLOORS=8 with request 10000000 from ground → 7 hops, position=10000000, never out of range.
